// File: rtl/proc_pkg.sv
// Shared processor definitions: bus widths, reset fetch address and the fetch-stage state type.
// The address increment helper keeps modulo-2^ADDR_W wrap in one place.
package proc_pkg;

    localparam int ADDR_W  = 8;
    localparam int BYTE_W  = 8;
    localparam int INSTR_W = 2 * BYTE_W;

    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        FETCH_HI = 2'b00,
        FETCH_LO = 2'b01,
        HOLD     = 2'b10
    } fetch_state_t;

    // Next byte address; the fetch pointer wraps naturally at the top of memory.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr);
        return addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle of the fetch stage: byte-wide program memory port on one side,
// instruction word handshake towards steuerwerk on the other.
interface instr_fetch_if;
    import proc_pkg::*;

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_req;
    logic               mem_ack;
    logic [BYTE_W-1:0]  mem_rdata;
    logic [INSTR_W-1:0] instructionbus;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  pc;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_ack,
        input  mem_rdata,
        output instructionbus,
        output instr_valid,
        output pc,
        input  instr_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_ack,
        output mem_rdata,
        input  instructionbus,
        input  instr_valid,
        input  pc,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch_checker.sv
// Protocol properties of the fetch stage: quiet memory port when halted or in reset,
// stable word while waiting for the consumer, stable address while a byte is outstanding.
module instr_fetch_checker
    import proc_pkg::*;
(
    input logic               clk,
    input logic               rst,
    input logic               halt,
    input logic               branch_en,
    input logic               mem_req,
    input logic               mem_ack,
    input logic [ADDR_W-1:0]  mem_addr,
    input logic               instr_valid,
    input logic               instr_ready,
    input logic [INSTR_W-1:0] instructionbus,
    input logic [ADDR_W-1:0]  pc
);

    a_rst_no_req: assert property (@(posedge clk) rst |-> !mem_req);

    a_halt_no_req: assert property (@(posedge clk) disable iff (rst) halt |-> !mem_req);

    a_word_stable: assert property (@(posedge clk) disable iff (rst)
        (instr_valid && !instr_ready && !branch_en)
        |=> (instr_valid && $stable(instructionbus) && $stable(pc)));

    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_req && !mem_ack && !branch_en) |=> $stable(mem_addr));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: assembles big-endian 16-bit words from two byte reads
// and offers them to steuerwerk; a branch redirects fetch and drops any partial word.
module instr_fetch
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    instr_fetch_if.master     bus,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              halt
);

    fetch_state_t       state_r;
    fetch_state_t       state_s;
    fetch_state_t       seq_state_s;
    logic [ADDR_W-1:0]  fptr_r;
    logic [ADDR_W-1:0]  fptr_s;
    logic [ADDR_W-1:0]  seq_fptr_s;
    logic [INSTR_W-1:0] instr_r;
    logic [INSTR_W-1:0] instr_s;
    logic [INSTR_W-1:0] seq_instr_s;
    logic               valid_r;
    logic               valid_s;
    logic               seq_valid_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_s;
    logic [ADDR_W-1:0]  seq_pc_s;
    logic               req_s;
    logic               ack_s;

    // Request decode; an ack without an outstanding request is ignored.
    always_comb begin
        req_s = 1'b0;
        if (((state_r == FETCH_HI) || (state_r == FETCH_LO)) && !halt && !rst) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        ack_s = bus.mem_ack & req_s;
    end

    // Normal fetch sequencing: high byte, low byte, then hold until consumed.
    always_comb begin
        seq_state_s = state_r;
        seq_fptr_s  = fptr_r;
        seq_instr_s = instr_r;
        seq_valid_s = valid_r;
        seq_pc_s    = pc_r;
        case (state_r)
            FETCH_HI: begin
                if (ack_s) begin
                    seq_instr_s[INSTR_W-1 -: BYTE_W] = bus.mem_rdata;
                    seq_pc_s    = fptr_r;
                    seq_fptr_s  = addr_inc(fptr_r);
                    seq_state_s = FETCH_LO;
                end else begin
                    seq_state_s = FETCH_HI;
                end
            end
            FETCH_LO: begin
                if (ack_s) begin
                    seq_instr_s[BYTE_W-1:0] = bus.mem_rdata;
                    seq_fptr_s  = addr_inc(fptr_r);
                    seq_valid_s = 1'b1;
                    seq_state_s = HOLD;
                end else begin
                    seq_state_s = FETCH_LO;
                end
            end
            HOLD: begin
                // Handshake completes even while halted; halt only blocks the next request.
                if (bus.instr_ready) begin
                    seq_valid_s = 1'b0;
                    seq_state_s = FETCH_HI;
                end else begin
                    seq_state_s = HOLD;
                end
            end
            default: begin
                seq_valid_s = 1'b0;
                seq_state_s = FETCH_HI;
            end
        endcase
    end

    // Branch override: a byte acked this cycle is dropped, the held word is withdrawn.
    always_comb begin
        state_s = seq_state_s;
        fptr_s  = seq_fptr_s;
        instr_s = seq_instr_s;
        valid_s = seq_valid_s;
        pc_s    = seq_pc_s;
        if (branch_en) begin
            state_s = FETCH_HI;
            fptr_s  = branch_addr;
            instr_s = instr_r;
            valid_s = 1'b0;
            pc_s    = pc_r;
        end else begin
            state_s = seq_state_s;
            fptr_s  = seq_fptr_s;
        end
    end

    // State and output registers; reset outranks branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH_HI;
            fptr_r  <= RESET_PC;
            instr_r <= {INSTR_W{1'b0}};
            valid_r <= 1'b0;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_s;
            fptr_r  <= fptr_s;
            instr_r <= instr_s;
            valid_r <= valid_s;
            pc_r    <= pc_s;
        end
    end

    assign bus.mem_req        = req_s;
    assign bus.mem_addr       = fptr_r;
    assign bus.instructionbus = instr_r;
    assign bus.instr_valid    = valid_r;
    assign bus.pc             = pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: redirects rebuild the expected word stream,
// a monitor pops and compares on every handshake; directed timing checks, then random traffic.
module tb_instr_fetch;
    import proc_pkg::*;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] word;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       branch_en;
    logic [7:0] branch_addr;
    logic       halt;

    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .halt        (halt)
    );

    instr_fetch_checker u_chk (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .branch_en      (branch_en),
        .mem_req        (bus.mem_req),
        .mem_ack        (bus.mem_ack),
        .mem_addr       (bus.mem_addr),
        .instr_valid    (bus.instr_valid),
        .instr_ready    (bus.instr_ready),
        .instructionbus (bus.instructionbus),
        .pc             (bus.pc)
    );

    logic [7:0] mem [0:255];
    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         hs_cnt = 0;
    int         wait_max = 0;
    bit         wait_rand = 1'b0;
    bit         junk_ack = 1'b0;
    int         wcnt = 0;
    int         wtgt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Expected stream: consecutive big-endian words starting at the redirect target.
    function automatic void refill(input logic [7:0] start);
        logic [7:0] a;
        exp_q.delete();
        a = start;
        for (int k = 0; k < 300; k++) begin
            exp_q.push_back({a, mem[a], mem[a + 8'd1]});
            a = a + 8'd2;
        end
    endfunction

    // Memory model: ack after wtgt wait cycles of an active request.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            wcnt = 0;
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 8'($urandom);
        end else if (bus.mem_req) begin
            if (wcnt >= wtgt) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                wcnt = 0;
                wtgt = wait_rand ? int'($urandom_range(wait_max, 0)) : wait_max;
            end else begin
                bus.mem_ack = 1'b0;
                bus.mem_rdata = 8'($urandom);
                wcnt++;
            end
        end else begin
            bus.mem_ack = junk_ack ? 1'($urandom_range(1, 0)) : 1'b0;
            bus.mem_rdata = 8'($urandom);
        end
    end

    // Monitor: handshake scoreboard plus hold/halt/address-stability checks.
    logic       p_valid, p_ready, p_branch, p_rst, p_req, p_ack;
    logic [15:0] p_word;
    logic [7:0] p_pc, p_addr;
    bit         have_prev = 1'b0;

    always @(negedge clk) begin
        #3;
        if (rst) begin
            chk("rst_req", bus.mem_req, 0);
        end else begin
            if (halt) chk("halt_req", bus.mem_req, 0);
            if (have_prev && !p_rst && !p_branch) begin
                if (p_valid && !p_ready) begin
                    chk("hold_valid", bus.instr_valid, 1);
                    chk("hold_word", bus.instructionbus, p_word);
                    chk("hold_pc", bus.pc, p_pc);
                end
                if (p_req && !p_ack) chk("wait_addr", bus.mem_addr, p_addr);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream got=%0h want=none at %0t", bus.instructionbus, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", bus.instructionbus, e.word);
                    chk("pc", bus.pc, e.pc);
                end
            end
        end
        p_valid = bus.instr_valid; p_ready = bus.instr_ready; p_branch = branch_en;
        p_rst = rst; p_req = bus.mem_req; p_ack = bus.mem_ack;
        p_word = bus.instructionbus; p_pc = bus.pc; p_addr = bus.mem_addr;
        have_prev = 1'b1;
    end

    logic       r_q = 1'b0;
    logic       b_q = 1'b0;
    logic [7:0] ba_q = 8'h00;

    // One clock cycle: apply the last redirect to the model, drive inputs, stop at the sample point.
    task automatic cyc(input logic r, input logic b, input logic [7:0] ba,
                       input logic h, input logic rdy);
        @(posedge clk);
        #1;
        if (r_q) refill(RESET_PC);
        else if (b_q) refill(ba_q);
        @(negedge clk);
        rst = r; branch_en = b; branch_addr = ba; halt = h; bus.instr_ready = rdy;
        r_q = r; b_q = b; ba_q = ba;
        #3;
    endtask

    int base;

    initial begin
        rst = 1'b1; branch_en = 1'b0; branch_addr = 8'h00; halt = 1'b0;
        bus.instr_ready = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Basic fetch and held word.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hAB; mem[3] = 8'hCD;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_word", bus.instructionbus, 0);
        chk("rst_pc", bus.pc, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("c0_req", bus.mem_req, 1); chk("c0_addr", bus.mem_addr, 8'h00); chk("c0_valid", bus.instr_valid, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("c1_addr", bus.mem_addr, 8'h01); chk("c1_valid", bus.instr_valid, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("c2_valid", bus.instr_valid, 1); chk("c2_word", bus.instructionbus, 16'h1234);
        chk("c2_pc", bus.pc, 8'h00); chk("c2_req", bus.mem_req, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("c3_valid", bus.instr_valid, 0); chk("c3_addr", bus.mem_addr, 8'h02); chk("c3_req", bus.mem_req, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            chk("stall_valid", bus.instr_valid, 1); chk("stall_word", bus.instructionbus, 16'hABCD);
            chk("stall_pc", bus.pc, 8'h02); chk("stall_req", bus.mem_req, 0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("accept_valid", bus.instr_valid, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("next_req", bus.mem_req, 1); chk("next_addr", bus.mem_addr, 8'h04);

        // Two wait cycles per byte.
        wait_max = 2; wtgt = 2;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 7; c++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            if (c <= 2) chk("w_addr_hi", bus.mem_addr, 8'h00);
            else if (c <= 5) chk("w_addr_lo", bus.mem_addr, 8'h01);
            if (c < 6) chk("w_valid_lo", bus.instr_valid, 0);
            else chk("w_valid_hi", bus.instr_valid, 1);
        end
        wait_max = 0; wtgt = 0;

        // Branch during the low-byte ack of the word at 10.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        mem[8'h10] = 8'h55; mem[8'h11] = 8'h66; mem[8'h40] = 8'h77; mem[8'h41] = 8'h88;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("br_req", bus.mem_req, 1); chk("br_addr", bus.mem_addr, 8'h10);
        cyc(1'b0, 1'b1, 8'h40, 1'b0, 1'b1);
        chk("br_lo_addr", bus.mem_addr, 8'h11);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("br2_valid", bus.instr_valid, 0); chk("br2_addr", bus.mem_addr, 8'h40); chk("br2_req", bus.mem_req, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("br2_lo_valid", bus.instr_valid, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("br_tgt_valid", bus.instr_valid, 1); chk("br_tgt_pc", bus.pc, 8'h40);
        chk("br_tgt_word", bus.instructionbus, 16'h7788);

        // Word straddling the top of memory.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        mem[8'hFF] = 8'h9A; mem[8'h00] = 8'hBC;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("wrap_addr_hi", bus.mem_addr, 8'hFF);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("wrap_addr_lo", bus.mem_addr, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("wrap_word", bus.instructionbus, 16'h9ABC); chk("wrap_pc", bus.pc, 8'hFF);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("wrap_next", bus.mem_addr, 8'h01);

        // Reset mid-word, then halted start.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        mem[0] = 8'h12; mem[1] = 8'h34;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            chk("halt_valid", bus.instr_valid, 0); chk("halt_req0", bus.mem_req, 0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("unhalt_req", bus.mem_req, 1); chk("unhalt_addr", bus.mem_addr, RESET_PC);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("unhalt_word", bus.instructionbus, 16'h1234); chk("unhalt_pc", bus.pc, RESET_PC);

        // Zero-wait throughput with ready tied high.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        base = hs_cnt;
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("throughput", 32'(hs_cnt - base), 10);

        // Random traffic against the stream model.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        wait_rand = 1'b1; wait_max = 3; junk_ack = 1'b1;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        base = hs_cnt;
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 100) == 0, ($urandom % 100) < 3, 8'($urandom),
                ($urandom % 100) < 10, ($urandom % 100) < 70);
        end
        chk("progress", 32'((hs_cnt - base) >= 50), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
